icache: RTL

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch unit and the memory controller's icache port. Hits return an instruction one cycle after the request. Misses issue a word fetch to the memory controller, fill the line and return the word. Obeys the global `readyIn` stall and `clearIn` mispredict flush.

---
 rtl/icache.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, between the fetch unit and the memory controller.
// Optional hit/miss counters are compiled in when ICACHE_PERF_EN is defined.
module icache #(
    parameter int INDEX_WIDTH = 4
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic        clearIn,
    input  logic        ifFlag,
    input  logic [31:0] ifAddr,
    output logic        ifOk,
    output logic [31:0] ifInst,
    output logic        memFlag,
    output logic [31:0] memAddr,
    input  logic        memOk,
    input  logic [31:0] memData
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
`endif
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t stateReg;

    logic [TAG_WIDTH-1:0]   tagMem  [LINES];
    logic [31:0]            dataMem [LINES];
    logic                   validReg[LINES];

    logic [INDEX_WIDTH-1:0] reqIndex;
    logic [TAG_WIDTH-1:0]   reqTag;
    logic [INDEX_WIDTH-1:0] missIndex;
    logic [TAG_WIDTH-1:0]   missTag;
    logic                   hit;
    logic                   accept;
    logic                   fillEn;

    assign reqIndex  = ifAddr[INDEX_WIDTH+1:2];
    assign reqTag    = ifAddr[31:INDEX_WIDTH+2];
    // The registered miss address doubles as the latched index/tag of the pending fill.
    assign missIndex = memAddr[INDEX_WIDTH+1:2];
    assign missTag   = memAddr[31:INDEX_WIDTH+2];

    assign hit    = validReg[reqIndex] && (tagMem[reqIndex] == reqTag);
    assign accept = readyIn && !clearIn && (stateReg == IDLE) && ifFlag;
    // A fill still lands when a flush coincides with memOk; only the response is dropped.
    assign fillEn = readyIn && (stateReg == MISS) && memOk;

    // Request is withdrawn in the completion cycle so the controller never sees a second fetch.
    assign memFlag = (stateReg == MISS) && !memOk;

    always_ff @(posedge clockIn) begin
        if (fillEn) begin
            tagMem[missIndex]  <= missTag;
            dataMem[missIndex] <= memData;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : gValid
            always_ff @(posedge clockIn or negedge resetIn) begin
                if (!resetIn) begin
                    validReg[gi] <= 1'b0;
                end else if (fillEn && (missIndex == INDEX_WIDTH'(gi))) begin
                    validReg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            stateReg <= IDLE;
            ifOk     <= 1'b0;
            ifInst   <= 32'd0;
            memAddr  <= 32'd0;
        end else if (readyIn) begin
            if (clearIn) begin
                stateReg <= IDLE;
                ifOk     <= 1'b0;
            end else begin
                case (stateReg)
                    IDLE: begin
                        if (ifFlag) begin
                            if (hit) begin
                                ifInst <= dataMem[reqIndex];
                                ifOk   <= 1'b1;
                            end else begin
                                memAddr  <= ifAddr & ~32'h3;
                                ifOk     <= 1'b0;
                                stateReg <= MISS;
                            end
                        end else begin
                            ifOk <= 1'b0;
                        end
                    end
                    MISS: begin
                        if (memOk) begin
                            ifInst   <= memData;
                            ifOk     <= 1'b1;
                            stateReg <= IDLE;
                        end else begin
                            ifOk <= 1'b0;
                        end
                    end
                    default: begin
                        stateReg <= IDLE;
                        ifOk     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            hitCount  <= 32'd0;
            missCount <= 32'd0;
        end else if (accept) begin
            if (hit) begin
                hitCount <= hitCount + 32'd1;
            end else begin
                missCount <= missCount + 32'd1;
            end
        end
    end
`endif

endmodule
